// File: rtl/spi_ram_cmd_ctrl.sv
// Command sequencer between the SPI slave's parallel side and a single-port RAM.
// Decodes 10-bit command words into address latches, RAM writes and RAM reads.
module spi_ram_cmd_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic [9:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC_WR,
        RD_ISSUE,
        RD_WAIT,
        TX_HOLD
    } state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t              state_q, state_d;
    logic                rx_valid_d_q;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_addr_vld_q, rd_addr_vld_d;
    logic [1:0]          wait_cnt_q, wait_cnt_d;
    logic                ss_seen_q, ss_seen_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cmd_err_q, cmd_err_d;

    logic                accept;
    logic [1:0]          opcode;
    logic [7:0]          payload;
    logic                ss_now;

    // A held-high rx_valid yields a single command: only its rising edge counts.
    assign accept  = rx_valid & ~rx_valid_d_q;
    assign opcode  = rx_data[9:8];
    assign payload = rx_data[7:0];
    assign ss_now  = ss_seen_q | SS_n;

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        rd_addr_vld_d = rd_addr_vld_q;
        wait_cnt_d    = wait_cnt_q;
        ss_seen_d     = ss_seen_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cmd_err_d     = 1'b0;

        if (accept && state_q != IDLE) begin
            cmd_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (opcode)
                        2'b00: wr_addr_d = ADDR_W'(payload);
                        2'b01: begin
                            state_d     = EXEC_WR;
                            mem_en_d    = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_addr_q;
                            mem_wdata_d = DATA_W'(payload);
                        end
                        2'b10: begin
                            rd_addr_d     = ADDR_W'(payload);
                            rd_addr_vld_d = 1'b1;
                        end
                        default: begin
                            if (!rd_addr_vld_q) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                state_d    = RD_ISSUE;
                                mem_en_d   = 1'b1;
                                mem_addr_d = rd_addr_q;
                                ss_seen_d  = 1'b0;
                            end
                        end
                    endcase
                end
            end
            EXEC_WR: begin
                state_d = IDLE;
                if (AUTO_INC) wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
            RD_ISSUE: begin
                state_d    = RD_WAIT;
                wait_cnt_d = 2'd1;
                ss_seen_d  = ss_now;
                if (AUTO_INC) rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
            RD_WAIT: begin
                ss_seen_d = ss_now;
                if (wait_cnt_q == LAT) begin
                    tx_data_d = mem_rdata;
                    // A frame that closed during the read still captures, but never presents.
                    if (ss_now) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = TX_HOLD;
                        tx_valid_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            TX_HOLD: begin
                if (SS_n) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rx_valid_d_q  <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            rd_addr_vld_q <= 1'b0;
            wait_cnt_q    <= 2'd0;
            ss_seen_q     <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_valid_d_q  <= rx_valid;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            rd_addr_vld_q <= rd_addr_vld_d;
            wait_cnt_q    <= wait_cnt_d;
            ss_seen_q     <= ss_seen_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_cmd_ctrl.sv
// Bench for spi_ram_cmd_ctrl: a behavioural RAM, a transaction-level model of the
// command set (address registers plus a memory image) and randomized command traffic.
module tb_spi_ram_cmd_ctrl;
    localparam int  RD_LAT   = 1;
    localparam bit  AUTO_INC = 1'b1;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       cmd_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr     = 0;
    int n_errp   = 0;

    // reference model state
    logic [7:0] exp_mem [256];
    logic [7:0] m_wr_addr;
    logic [7:0] m_rd_addr;
    bit         m_rd_vld;

    spi_ram_cmd_ctrl #(
        .ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT), .AUTO_INC(AUTO_INC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural single-port RAM with RD_LAT cycles of read latency
    logic [7:0] ram [256];
    logic [7:0] rd_pipe [RD_LAT];
    logic       ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 11);
            ram_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) rd_pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) n_wr++;
        if (cmd_err) n_errp++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr_addr = 8'h00;
        m_rd_addr = 8'h00;
        m_rd_vld  = 1'b0;
    endtask

    // One command, checked cycle by cycle from N+1 (inputs driven on the falling edge).
    task automatic do_cmd(input logic [9:0] w, input bit ss_abort, input int hold, input bit poke);
        logic [7:0] p;
        logic [7:0] exp_d;
        p = w[7:0];
        @(negedge clk); rx_data = w; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        case (w[9:8])
            2'b00: begin
                check("wa_mem_en", mem_en, 0);
                check("wa_busy", busy, 0);
                check("wa_err", cmd_err, 0);
                m_wr_addr = p;
            end
            2'b01: begin
                check("wr_en", mem_en, 1);
                check("wr_we", mem_we, 1);
                check("wr_addr", mem_addr, m_wr_addr);
                check("wr_data", mem_wdata, p);
                check("wr_busy", busy, 1);
                exp_mem[m_wr_addr] = p;
                if (AUTO_INC) m_wr_addr = m_wr_addr + 8'd1;
                @(negedge clk);
                check("wr_en_drop", mem_en, 0);
                check("wr_idle", busy, 0);
            end
            2'b10: begin
                check("ra_mem_en", mem_en, 0);
                check("ra_err", cmd_err, 0);
                m_rd_addr = p;
                m_rd_vld  = 1'b1;
            end
            default: begin
                if (!m_rd_vld) begin
                    check("rd_err", cmd_err, 1);
                    check("rd_err_en", mem_en, 0);
                    check("rd_err_tx", tx_valid, 0);
                    @(negedge clk);
                    check("rd_err_pulse", cmd_err, 0);
                    check("rd_err_busy", busy, 0);
                end else begin
                    check("rd_en", mem_en, 1);
                    check("rd_we", mem_we, 0);
                    check("rd_addr", mem_addr, m_rd_addr);
                    exp_d = exp_mem[m_rd_addr];
                    if (AUTO_INC) m_rd_addr = m_rd_addr + 8'd1;
                    if (ss_abort) SS_n = 1'b1;
                    for (int i = 0; i < RD_LAT; i++) begin
                        @(negedge clk);
                        check("rd_wait_tx", tx_valid, 0);
                        check("rd_wait_busy", busy, 1);
                        check("rd_wait_en", mem_en, 0);
                    end
                    @(negedge clk);
                    check("rd_tx_data", tx_data, exp_d);
                    if (ss_abort) begin
                        check("rd_abort_tx", tx_valid, 0);
                        check("rd_abort_busy", busy, 0);
                        SS_n = 1'b0;
                    end else begin
                        check("rd_tx_valid", tx_valid, 1);
                        for (int i = 0; i < hold; i++) begin
                            @(negedge clk);
                            check("hold_tx_valid", tx_valid, 1);
                            check("hold_tx_data", tx_data, exp_d);
                        end
                        if (poke) begin
                            rx_data = 10'h177; rx_valid = 1'b1;
                            @(negedge clk); rx_valid = 1'b0;
                            check("poke_err", cmd_err, 1);
                            check("poke_en", mem_en, 0);
                            check("poke_tx_data", tx_data, exp_d);
                            check("poke_tx_valid", tx_valid, 1);
                            @(negedge clk);
                            check("poke_err_pulse", cmd_err, 0);
                        end
                        SS_n = 1'b1;
                        check("tx_last_valid", tx_valid, 1);
                        @(negedge clk); SS_n = 1'b0;
                        check("tx_drop", tx_valid, 0);
                        check("tx_keep", tx_data, exp_d);
                        check("tx_idle", busy, 0);
                    end
                end
            end
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_err"}, cmd_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; #1;
        check_reset_outputs("rst");
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    // Reset while a read is outstanding: at=1 hits RD_ISSUE, at=2 hits RD_WAIT.
    task automatic read_reset(input int at);
        @(negedge clk); rx_data = 10'h300; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        check("rr_en", mem_en, 1);
        if (at > 1) begin
            @(negedge clk);
            check("rr_wait_busy", busy, 1);
        end
        rst_n = 1'b0; #1;
        check_reset_outputs("rr");
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int w0, e0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 37 + 11);
        model_reset();
        rst_n = 1'b0; SS_n = 1'b1; rx_valid = 1'b0; rx_data = '0;
        #1;
        check_reset_outputs("init");
        check("init_tx_data", tx_data, 0);
        check("init_mem_addr", mem_addr, 0);
        check("init_mem_wdata", mem_wdata, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1; SS_n = 1'b0;

        // writes with auto-increment, then read back
        do_cmd(10'h010, 0, 0, 0);
        do_cmd(10'h1A5, 0, 0, 0);
        do_cmd(10'h13C, 0, 0, 0);
        do_cmd(10'h210, 0, 0, 0);
        do_cmd(10'h300, 0, 3, 0);
        do_cmd(10'h300, 0, 1, 0);

        // held-high rx_valid is a single command
        w0 = n_wr; e0 = n_errp;
        @(negedge clk); rx_data = 10'h155; rx_valid = 1'b1;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("held_one_write", n_wr - w0, 1);
        check("held_no_err", n_errp - e0, 0);
        exp_mem[m_wr_addr] = 8'h55;
        if (AUTO_INC) m_wr_addr = m_wr_addr + 8'd1;

        // command dropped during TX_HOLD, frame closed mid-read
        do_cmd(10'h210, 0, 0, 0);
        w0 = n_wr;
        do_cmd(10'h300, 0, 2, 1);
        check("poke_no_write", n_wr - w0, 0);
        do_cmd(10'h300, 0, 0, 0);
        do_cmd(10'h300, 1, 0, 0);
        do_cmd(10'h300, 0, 0, 0);

        // address wrap and write-then-read of the same location
        do_cmd(10'h0FF, 0, 0, 0);
        do_cmd(10'h1C3, 0, 0, 0);
        do_cmd(10'h1D4, 0, 0, 0);
        do_cmd(10'h2FF, 0, 0, 0);
        do_cmd(10'h300, 0, 0, 0);
        do_cmd(10'h300, 0, 0, 0);
        do_cmd(10'h1E7, 0, 0, 0);
        do_cmd(10'h201, 0, 0, 0);
        do_cmd(10'h300, 0, 0, 0);

        // read-data without a read address after reset
        do_reset();
        do_cmd(10'h300, 0, 0, 0);

        // reset in the middle of a read clears rd_addr_vld
        do_cmd(10'h220, 0, 0, 0);
        read_reset(2);
        do_cmd(10'h300, 0, 0, 0);
        do_cmd(10'h230, 0, 0, 0);
        read_reset(1);
        do_cmd(10'h300, 0, 0, 0);

        // randomized command traffic
        for (int k = 0; k < 80; k++) begin
            do_cmd(10'($urandom_range(0, 1023)), ($urandom_range(0, 4) == 0),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
